// File: rtl/ram_hs_arb.sv
// Shares one valid/ready SRAM wrapper among NUM_PORT clients with at most one read in flight.
// Define RAM_HS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, port 0 highest.
module ram_hs_arb #(
  parameter int NUM_PORT = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 128,
  parameter int ID_W     = $clog2(NUM_PORT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORT-1:0]          c_wvalid,
  output logic [NUM_PORT-1:0]          c_wready,
  input  logic [NUM_PORT*ADDR_W-1:0]   c_waddr,
  input  logic [NUM_PORT*DATA_W-1:0]   c_wdata,
  input  logic [NUM_PORT-1:0]          c_arvalid,
  output logic [NUM_PORT-1:0]          c_arready,
  input  logic [NUM_PORT*ADDR_W-1:0]   c_araddr,
  output logic [NUM_PORT-1:0]          c_rvalid,
  input  logic [NUM_PORT-1:0]          c_rready,
  output logic [DATA_W-1:0]            c_rdata,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic [ADDR_W-1:0]            m_waddr,
  output logic [DATA_W-1:0]            m_wdata,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  output logic [ADDR_W-1:0]            m_araddr,
  input  logic                         m_rvalid,
  output logic                         m_rready,
  input  logic [DATA_W-1:0]            m_rdata
);

  // First asserted request found when scanning upward (with wrap) from base.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_PORT-1:0] req,
                                           input logic [ID_W-1:0]     base);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORT; k++) begin
      idx = (int'(base) + k) % NUM_PORT;
      if (!found && req[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  logic            busy_q, busy_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] wbase, rbase;
  logic [ID_W-1:0] wg, rg;
  logic            any_w, any_r;
  logic            issue_ok, rd_hs, ar_acc;

`ifdef RAM_HS_ARB_RR_EN
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return ID_W'((int'(id) + 1) % NUM_PORT);
  endfunction

  logic [ID_W-1:0] wptr_q, wptr_d;
  logic [ID_W-1:0] rptr_q, rptr_d;

  assign wbase = wptr_q;
  assign rbase = rptr_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (m_wvalid && m_wready) wptr_d = next_id(wg);
    if (ar_acc)               rptr_d = next_id(rg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`else
  assign wbase = '0;
  assign rbase = '0;
`endif

  always_comb begin
    any_w = |c_wvalid;
    any_r = |c_arvalid;
    wg    = pick(c_wvalid, wbase);
    rg    = pick(c_arvalid, rbase);

    m_wvalid     = any_w;
    m_waddr      = c_waddr[int'(wg)*ADDR_W +: ADDR_W];
    m_wdata      = c_wdata[int'(wg)*DATA_W +: DATA_W];
    c_wready     = '0;
    c_wready[wg] = any_w & m_wready;

    // A completing read frees the slot in the same cycle, so reads chain without a bubble.
    m_rready  = busy_q & c_rready[owner_q];
    rd_hs     = m_rvalid & m_rready;
    issue_ok  = ~busy_q | rd_hs;
    m_arvalid = any_r & issue_ok;
    m_araddr  = c_araddr[int'(rg)*ADDR_W +: ADDR_W];
    ar_acc    = m_arvalid & m_arready;

    c_arready     = '0;
    c_arready[rg] = ar_acc;

    // Stray SRAM data while idle is never routed to a client.
    c_rvalid          = '0;
    c_rvalid[owner_q] = m_rvalid & busy_q;
    c_rdata           = m_rdata;
  end

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    if (ar_acc) begin
      busy_d  = 1'b1;
      owner_d = rg;
    end else if (rd_hs) begin
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: doc/ram_hs_arb.md
# ram_hs_arb

Multi-requester arbiter for one handshake single-port-style SRAM wrapper (separate write channel, read-address channel and read-data channel, all valid/ready). It shares the SRAM between `NUM_PORT` clients, such as the point-fetch, weight-fetch and write-back engines. It arbitrates writes and reads independently, keeps at most one read outstanding, and routes returned read data back to the client that issued it.

## Interface
- `NUM_PORT`, 4: number of client ports, 2..8.
- `ADDR_W`, 6: SRAM word address width.
- `DATA_W`, 128: SRAM data width.
- `ID_W`, `C_LOG_2(NUM_PORT)`: width of the port index.

Ports (per-client buses are flattened; client i occupies slice i):
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `c_wvalid` in NUM_PORT: client write requests.
- `c_wready` out NUM_PORT: client write accepted.
- `c_waddr` in NUM_PORT*ADDR_W: client write addresses.
- `c_wdata` in NUM_PORT*DATA_W: client write data.
- `c_arvalid` in NUM_PORT: client read-address requests.
- `c_arready` out NUM_PORT: client read address accepted.
- `c_araddr` in NUM_PORT*ADDR_W: client read addresses.
- `c_rvalid` out NUM_PORT: read data valid to its owner.
- `c_rready` in NUM_PORT: client read data taken.
- `c_rdata` out DATA_W: shared read-data bus; qualified by `c_rvalid[i]`.
- `m_wvalid`/`m_wready`/`m_waddr`/`m_wdata`: SRAM write channel, out/in/out/out, widths 1/1/ADDR_W/DATA_W.
- `m_arvalid`/`m_arready`/`m_araddr`: SRAM read-address channel, out/in/out, widths 1/1/ADDR_W.
- `m_rvalid`/`m_rready`/`m_rdata`: SRAM read-data channel, in/out/in, widths 1/1/DATA_W.

## Operation

**Write arbiter (combinational grant)**
- The write winner `wg` is chosen among asserted `c_wvalid`, starting at pointer `wptr`.
- `m_wvalid` = any `c_wvalid`.
- `m_waddr`/`m_wdata` = slice `wg`.
- `c_wready[wg]` = `m_wready`; all other `c_wready` bits are 0.
- On `m_wvalid & m_wready`: `wptr` <= (`wg`+1) mod NUM_PORT.

**Read arbiter**
- State `busy` (1 bit) and `owner` (ID_W bits) mark the single outstanding read.
- `issue_ok` = !`busy` | (`m_rvalid` & `m_rready`).
- Read winner `rg` is chosen among `c_arvalid`, starting at `rptr`.
- `m_arvalid` = any `c_arvalid` & `issue_ok`; `m_araddr` = slice `rg`.
- `c_arready[rg]` = `m_arready` & `issue_ok`; all others 0.
- On an accepted read address: `owner` <= `rg`, `busy` <= 1, `rptr` <= (`rg`+1) mod NUM_PORT.
- Return path: `c_rvalid[owner]` = `m_rvalid` & `busy`; `m_rready` = `c_rready[owner]` when `busy`, else 0.
- On data handshake with no new issue in the same cycle: `busy` <= 0.
- Data handshake and new issue in the same cycle: `busy` stays 1 and `owner` takes the new winner. This gives back-to-back reads with no bubble.
- `c_rdata` = `m_rdata` (pass-through, no register).
- `m_rvalid` while !`busy` is a protocol violation. It is ignored, and no `c_rvalid` is raised.

**Boundary conditions**
- A read and a write to the same address in the same cycle are both forwarded; ordering is the SRAM's responsibility.
- A client may hold `c_arvalid` without `c_rready`. Its read issues, and the channel then stalls until that client takes the data.
- Clients must hold valid/addr/data stable until ready.

## Timing
- Reset values:
  - `busy`=0, `owner`=0, `wptr`=0, `rptr`=0.
  - All `c_wready`, `c_arready` and `c_rvalid` bits = 0.
  - `m_wvalid`=0, `m_arvalid`=0, `m_rready`=0 (given idle inputs).
- Grant path adds zero cycles: request to SRAM strobe is combinational.
- Read latency to the client equals SRAM latency (1 cycle when the SRAM is ready).
- Sustained read throughput: 1 read per cycle when the owner holds `c_rready`=1.
- Asserting `rst_n` mid-read clears `busy`. Any SRAM data still pending is dropped.

## Configuration
- `RAM_HS_ARB_RR_EN` defined: both arbiters are round-robin as above; pointers advance on each grant.
- Not defined: fixed priority, lowest index wins. `wptr`/`rptr` are removed and treated as 0.

## Test plan
- Idle after reset: all outputs 0; `m_arvalid`=0 with `c_arvalid`=0.
- Write contention (RR): ports 0,1,2 hold `c_wvalid` with `m_wready`=1 → grants in order 0,1,2,0; each write's addr/data appear on `m_w*` in its grant cycle.
- Read routing: port 2 reads addr 5 → `owner`=2; next cycle `c_rvalid`=4'b0100 with `c_rdata`=mem[5].
- Back-to-back reads: ports 1 and 3 request continuously with `c_rready` all 1 → reads alternate 1,3,1,3 with no idle cycle; each `c_rvalid` goes to the correct port.
- Owner stall: port 0 read completes with `c_rready[0]`=0 for 3 cycles → `m_arvalid`=0 and port 1 gets no `c_arready` until port 0 takes its data.
- Fixed-priority build (macro undefined): ports 0 and 3 both request every cycle → port 0 is always granted; port 3 is granted only once port 0 drops its request.
